// File: rtl/username_pkg.sv
// Shared definitions for the username character stream (transmitter and recognizer).
// ASCII constants, character-class helpers and FSM state encoding.
package username_pkg;

   localparam logic [7:0] CH_DOT = 8'h2E;
   localparam logic [7:0] CH_0   = 8'h30;
   localparam logic [7:0] CH_9   = 8'h39;
   localparam logic [7:0] CH_a   = 8'h61;
   localparam logic [7:0] CH_z   = 8'h7A;
   localparam logic [7:0] CH_A   = 8'h41;
   localparam logic [7:0] CH_Z   = 8'h5A;

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] CONV = 3'd1;
   localparam logic [2:0] LET  = 3'd2;
   localparam logic [2:0] DOT  = 3'd3;
   localparam logic [2:0] DIG  = 3'd4;

   function automatic logic is_letter(input logic [7:0] c);
      return ((c >= CH_a) && (c <= CH_z)) || ((c >= CH_A) && (c <= CH_Z));
   endfunction

   function automatic logic is_digit(input logic [7:0] c);
      return (c >= CH_0) && (c <= CH_9);
   endfunction

endpackage

// File: rtl/username_tx_bin2bcd.sv
// Iterative binary-to-BCD converter (shift/add-3), one bit per cycle.
// o_done pulses for one cycle after exactly NUM_W shift steps; o_bcd then holds until next load.
module bin2bcd #(
   parameter int NUM_W  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_load,
   input  logic [NUM_W-1:0]      i_bin,
   output logic                  o_done,
   output logic [4*DIGITS-1:0]   o_bcd
);

   localparam int CW = $clog2(NUM_W + 1);

   logic [NUM_W-1:0]    r_bin;
   logic [4*DIGITS-1:0] r_bcd;
   logic [4*DIGITS-1:0] w_adj;
   logic [CW-1:0]       r_cnt;
   logic                r_active;
   logic                r_done;

   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? (d + 4'd3) : d;
   endfunction

   // Per-digit add-3 correction applied before each shift.
   always_comb begin
      w_adj = '0;
      for (int d = 0; d < DIGITS; d++) begin
         w_adj[4*d +: 4] = add3(r_bcd[4*d +: 4]);
      end
   end

   // Shift engine and step counter.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_bin    <= '0;
         r_bcd    <= '0;
         r_cnt    <= '0;
         r_active <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_load) begin
            r_bin    <= i_bin;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b1;
         end else if (r_active) begin
            {r_bcd, r_bin} <= {w_adj[4*DIGITS-2:0], r_bin, 1'b0};
            r_cnt          <= r_cnt + CW'(1);
            if (r_cnt == CW'(NUM_W - 1)) begin
               r_active <= 1'b0;
               r_done   <= 1'b1;
            end else begin
               r_active <= 1'b1;
            end
         end else begin
            r_active <= 1'b0;
         end
      end
   end

   assign o_done = r_done;
   assign o_bcd  = r_bcd;

endmodule

// File: rtl/username_tx.sv
// Username stream transmitter: sends buffered letters, '.', then a number in decimal
// without leading zeros over a valid/ready handshake.
module username_tx #(
   parameter int DEPTH  = 8,
   parameter int NUM_W  = 16,
   parameter int DIGITS = 5
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_wr_en,
   input  logic [7:0]       i_wr_char,
   input  logic             i_start,
   input  logic [NUM_W-1:0] i_number,
   output logic             o_busy,
   output logic [7:0]       o_name,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_last,
   output logic             o_err
);

   import username_pkg::*;

   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [2:0]          r_state;
   logic [7:0]          r_buf [DEPTH];
   logic [CW-1:0]       r_count;
   logic [IW-1:0]       r_idx;
   logic [DW-1:0]       r_dig;
   logic [7:0]          r_name;
   logic                r_valid;
   logic                r_last;
   logic                r_busy;
   logic                r_err;

   logic                w_start_ok;
   logic                w_wr_ok;
   logic                w_acc;
   logic                w_done;
   logic [4*DIGITS-1:0] w_bcd;
   logic [IW-1:0]       w_idx_nxt;
   logic [DW-1:0]       w_dig_m1;
   logic [3:0]          w_cur_dig;
   logic [3:0]          w_nxt_dig;
   logic                w_last_let;

   // Index of the most significant non-zero digit; zero when the value is zero.
   function automatic logic [DW-1:0] msd_index(input logic [4*DIGITS-1:0] b);
      logic [DW-1:0] k;
      k = '0;
      for (int d = 0; d < DIGITS; d++) begin
         if (b[4*d +: 4] != 4'd0) k = DW'(d);
         else                     k = k;
      end
      return k;
   endfunction

   assign w_start_ok = (r_state == IDLE) && i_start && (r_count != '0);
   assign w_wr_ok    = i_reset && (r_state == IDLE) && !i_start && i_wr_en &&
                       is_letter(i_wr_char) && (r_count < CW'(DEPTH));
   assign w_acc      = r_valid && i_ready;
   assign w_idx_nxt  = r_idx + IW'(1);
   assign w_dig_m1   = r_dig - DW'(1);
   assign w_last_let = ((CW'(r_idx) + CW'(1)) == r_count);

   bin2bcd #(
      .NUM_W  (NUM_W),
      .DIGITS (DIGITS)
   ) u_bin2bcd (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_load  (w_start_ok),
      .i_bin   (i_number),
      .o_done  (w_done),
      .o_bcd   (w_bcd)
   );

   // Select the current digit and the next lower one for the DIG sequence.
   always_comb begin
      w_cur_dig = 4'd0;
      w_nxt_dig = 4'd0;
      for (int d = 0; d < DIGITS; d++) begin
         if (DW'(d) == r_dig)    w_cur_dig = w_bcd[4*d +: 4];
         else                    w_cur_dig = w_cur_dig;
         if (DW'(d) == w_dig_m1) w_nxt_dig = w_bcd[4*d +: 4];
         else                    w_nxt_dig = w_nxt_dig;
      end
   end

   // Letter storage; only written with accepted letters while idle.
   always_ff @(posedge i_clk) begin
      if (w_wr_ok) begin
         r_buf[r_count[IW-1:0]] <= i_wr_char;
      end
   end

   // Control FSM, handshake registers and error pulse.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state <= IDLE;
         r_count <= '0;
         r_idx   <= '0;
         r_dig   <= '0;
         r_name  <= 8'h00;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  if (r_count == '0) begin
                     r_err <= 1'b1;
                  end else begin
                     r_busy  <= 1'b1;
                     r_state <= CONV;
                     r_err   <= i_wr_en;
                  end
               end else if (i_wr_en) begin
                  if (w_wr_ok) r_count <= r_count + CW'(1);
                  else         r_err   <= 1'b1;
               end else begin
                  r_err <= 1'b0;
               end
            end
            CONV: begin
               r_err <= i_start || i_wr_en;
               if (w_done) begin
                  r_state <= LET;
                  r_idx   <= '0;
                  r_name  <= r_buf[0];
                  r_valid <= 1'b1;
                  r_dig   <= msd_index(w_bcd);
               end else begin
                  r_state <= CONV;
               end
            end
            LET: begin
               r_err <= i_start || i_wr_en;
               if (w_acc && w_last_let) begin
                  r_name  <= CH_DOT;
                  r_state <= DOT;
               end else if (w_acc) begin
                  r_idx  <= w_idx_nxt;
                  r_name <= r_buf[w_idx_nxt];
               end else begin
                  r_state <= LET;
               end
            end
            DOT: begin
               r_err <= i_start || i_wr_en;
               if (w_acc) begin
                  r_name  <= CH_0 + {4'h0, w_cur_dig};
                  r_last  <= (r_dig == '0);
                  r_state <= DIG;
               end else begin
                  r_state <= DOT;
               end
            end
            DIG: begin
               r_err <= i_start || i_wr_en;
               if (w_acc && (r_dig == '0)) begin
                  r_valid <= 1'b0;
                  r_last  <= 1'b0;
                  r_busy  <= 1'b0;
                  r_count <= '0;
                  r_state <= IDLE;
               end else if (w_acc) begin
                  r_dig  <= w_dig_m1;
                  r_name <= CH_0 + {4'h0, w_nxt_dig};
                  r_last <= (r_dig == DW'(1));
               end else begin
                  r_state <= DIG;
               end
            end
            default: begin
               r_state <= IDLE;
               r_valid <= 1'b0;
               r_last  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy  = r_busy;
   assign o_name  = r_name;
   assign o_valid = r_valid;
   assign o_last  = r_last;
   assign o_err   = r_err;

endmodule
